// File: rtl/halfpel_filter_stream.sv
// halfpel_filter_stream
// Streaming half-pel interpolator: takes one row of N_PIX reference pixels per
// handshake and produces N_PIX-1 interpolated pixels in copy, horizontal,
// vertical or diagonal mode. Rows are grouped into blocks of BLK_ROWS input
// rows; vertical and diagonal modes consume the first row as a priming row.
module halfpel_filter_stream #(
  parameter int PIX_BITS = 8,
  parameter int N_PIX    = 8,
  parameter int BLK_ROWS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_PIX*PIX_BITS-1:0]     in_pix,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(N_PIX-1)*PIX_BITS-1:0] out_pix,
  output logic                          out_last,
  output logic                          busy,
  output logic                          blk_done
);

  localparam int IN_W  = N_PIX * PIX_BITS;
  localparam int OUT_W = (N_PIX - 1) * PIX_BITS;
  localparam int CNT_W = $clog2(BLK_ROWS + 1);
  // Counter value while the final input row of the block is being accepted
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         mode_reg;
  logic [IN_W-1:0]    prev_row_reg;
  logic [CNT_W-1:0]   row_cnt_reg;
  logic               all_in_reg;      // final input row of the block taken
  logic               busy_reg;
  logic               out_valid_reg;
  logic               out_last_reg;
  logic [OUT_W-1:0]   out_pix_reg;
  logic [OUT_W-1:0]   filt_row;

  logic in_fire;
  logic out_fire;
  logic last_fire;
  logic start_fire;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid_reg & out_ready;
  assign last_fire  = out_fire & out_last_reg;
  assign start_fire = (state_reg == IDLE) & start;

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_pix   = out_pix_reg;
  assign busy      = busy_reg;
  // Completion is reported on the very cycle the last row leaves
  assign blk_done  = last_fire;

  // Input acceptance: depends only on state, output register and out_ready
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      PRIME:   in_ready = 1'b1;
      RUN:     in_ready = ~all_in_reg & (~out_valid_reg | out_ready);
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic for the block framing FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = mode[1] ? PRIME : RUN;
        end
      end
      PRIME: begin
        if (in_fire) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Block control: latched mode, accepted-row counter, busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg    <= 2'd0;
      row_cnt_reg <= '0;
      all_in_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      if (start_fire) begin
        mode_reg    <= mode;
        row_cnt_reg <= '0;
        all_in_reg  <= 1'b0;
        busy_reg    <= 1'b1;
      end
      if (in_fire) begin
        row_cnt_reg <= row_cnt_reg + 1'b1;
        if (row_cnt_reg == LAST_IDX) begin
          all_in_reg <= 1'b1;
        end
      end
      if (last_fire) begin
        all_in_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end
    end
  end

  // Previous-row register: priming row, then every row in vertical/diagonal modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_row_reg <= '0;
    end else if (in_fire && (state_reg == PRIME || mode_reg[1])) begin
      prev_row_reg <= in_pix;
    end
  end

  // Output register: loads on a RUN accept, empties on consume, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_pix_reg   <= '0;
    end else if (in_fire && state_reg == RUN) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= (row_cnt_reg == LAST_IDX);
      out_pix_reg   <= filt_row;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  // Per-pixel interpolation: a/b from the current row, c/d from prev_row
  genvar gi;
  generate
    for (gi = 0; gi < N_PIX - 1; gi++) begin : g_pix
      logic [PIX_BITS-1:0] a;
      logic [PIX_BITS-1:0] b;
      logic [PIX_BITS-1:0] c;
      logic [PIX_BITS-1:0] d;
      logic [PIX_BITS:0]   sum_h;
      logic [PIX_BITS:0]   sum_v;
      logic [PIX_BITS+1:0] sum_d;
      logic [PIX_BITS-1:0] res;

      assign a = in_pix[gi*PIX_BITS +: PIX_BITS];
      assign b = in_pix[(gi+1)*PIX_BITS +: PIX_BITS];
      assign c = prev_row_reg[gi*PIX_BITS +: PIX_BITS];
      assign d = prev_row_reg[(gi+1)*PIX_BITS +: PIX_BITS];

      // Rounded averages with one or two guard bits; the maximum result fits
      // back into PIX_BITS, so truncation after the shift is exact.
      assign sum_h = {1'b0, a} + {1'b0, b} + (PIX_BITS+1)'(1);
      assign sum_v = {1'b0, c} + {1'b0, a} + (PIX_BITS+1)'(1);
      assign sum_d = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d}
                   + (PIX_BITS+2)'(2);

      // Mode select for this pixel
      always_comb begin
        res = a;
        case (mode_reg)
          2'd0:    res = a;
          2'd1:    res = PIX_BITS'(sum_h >> 1);
          2'd2:    res = PIX_BITS'(sum_v >> 1);
          default: res = PIX_BITS'(sum_d >> 2);
        endcase
      end

      assign filt_row[gi*PIX_BITS +: PIX_BITS] = res;
    end
  endgenerate

endmodule

// File: tb/tb_halfpel_filter_stream.sv
// tb_halfpel_filter_stream
// Directed blocks against a row-level behavioural model of the filter, plus
// literal expectations for the hand-computed rows.
module tb_halfpel_filter_stream;

  localparam int PB  = 8;
  localparam int N   = 8;
  localparam int BLK = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [N*PB-1:0]     in_pix = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [(N-1)*PB-1:0] out_pix;
  logic                out_last;
  logic                busy;
  logic                blk_done;

  halfpel_filter_stream #(.PIX_BITS(PB), .N_PIX(N), .BLK_ROWS(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_last(out_last), .busy(busy), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [(N-1)*PB-1:0] pix;
    bit                  last;
  } exp_t;

  exp_t            q[$];
  bit              m_active = 0;
  bit              m_prime = 0;
  int              m_mode = 0;
  int              m_rows = 0;
  logic [N*PB-1:0] m_prev = '0;
  logic [(N-1)*PB-1:0] cap [16];
  int              cap_n = 0;
  logic [N*PB-1:0] rows [BLK];

  function automatic logic [(N-1)*PB-1:0] model_row(input int md, input logic [N*PB-1:0] cur,
                                                    input logic [N*PB-1:0] prv);
    logic [(N-1)*PB-1:0] r;
    int a, b, c, d, v;
    r = '0;
    for (int k = 0; k < N - 1; k++) begin
      a = int'(cur[k*PB +: PB]);
      b = int'(cur[(k+1)*PB +: PB]);
      c = int'(prv[k*PB +: PB]);
      d = int'(prv[(k+1)*PB +: PB]);
      case (md)
        0:       v = a;
        1:       v = (a + b + 1) / 2;
        2:       v = (c + a + 1) / 2;
        default: v = (a + b + c + d + 2) / 4;
      endcase
      r[k*PB +: PB] = PB'(v);
    end
    return r;
  endfunction

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_active = 0;
      m_prime = 0;
      m_rows = 0;
      m_prev = '0;
    end else begin
      bit exp_rdy;
      bit exp_done;
      exp_rdy = !m_active ? 1'b0 : m_prime ? 1'b1 : (m_rows == BLK) ? 1'b0
              : (q.size() == 0 || out_ready);
      exp_done = (q.size() > 0) && out_ready && q[0].last;
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_pix", out_pix, q[0].pix);
        chk("out_last", out_last, q[0].last);
      end
      chk("busy", busy, m_active);
      chk("in_ready", in_ready, exp_rdy);
      chk("blk_done", blk_done, exp_done);

      if (start && !m_active) begin
        m_active = 1;
        m_mode = int'(mode);
        m_prime = mode[1];
        m_rows = 0;
        cap_n = 0;
      end else begin
        if (q.size() > 0 && out_valid && out_ready) begin
          $display("row out: mode %0d idx %0d pix %h last %0d", m_mode, cap_n, out_pix, out_last);
          if (cap_n < 16) cap[cap_n] = out_pix;
          cap_n++;
          if (q[0].last) m_active = 0;
          void'(q.pop_front());
        end
        if (in_valid && in_ready && m_active) begin
          m_rows++;
          if (m_prime) begin
            m_prev = in_pix;
            m_prime = 0;
          end else begin
            q.push_back('{pix: model_row(m_mode, in_pix, m_prev), last: (m_rows == BLK)});
            if (m_mode >= 2) m_prev = in_pix;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_blk_done"}, blk_done, 0);
    chk({tag, "_out_pix"}, out_pix, 0);
  endtask

  task automatic run_block(input int md, input int stall_at, input int stall_len,
                           input int inj_at, input int abort_at);
    int r = 0;
    int cyc = 0;
    int n = 0;
    bit acc;
    @(posedge clk); #1;
    mode = 2'(md);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (r < BLK && cyc < 200) begin
      in_valid = 1'b1;
      in_pix = rows[r];
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == inj_at) begin
        start = 1'b1;
        mode = 2'(md ^ 2);
      end else begin
        start = 1'b0;
      end
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) r++;
      cyc++;
    end
    chk("rows_sent", r, BLK);
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("block_end_busy", busy, 0);
  endtask

  logic [(N-1)*PB-1:0] all_ff;
  logic [(N-1)*PB-1:0] all_0c;
  logic [(N-1)*PB-1:0] all_0d;

  initial begin
    for (int k = 0; k < N - 1; k++) begin
      all_ff[k*PB +: PB] = 8'hff;
      all_0c[k*PB +: PB] = 8'h0c;
      all_0d[k*PB +: PB] = 8'h0d;
    end

    #1;
    check_zero("reset");
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode 1: ramp 0..7 in every row -> 1..7
    for (int r = 0; r < BLK; r++)
      for (int k = 0; k < N; k++) rows[r][k*PB +: PB] = PB'(k);
    run_block(1, -1, 0, -1, -1);
    chk("m1_count", cap_n, 8);
    chk("m1_row0", cap[0], 56'h07060504030201);
    chk("m1_row7", cap[7], 56'h07060504030201);

    // Mode 3: saturated input stays 255, priming row gives no output
    for (int r = 0; r < BLK; r++) rows[r] = '1;
    run_block(3, -1, 0, -1, -1);
    chk("m3_count", cap_n, 7);
    chk("m3_row0", cap[0], all_ff);
    chk("m3_row6", cap[6], all_ff);

    // Mode 2: 10 then 13 -> 12, then 13 -> 13
    for (int r = 0; r < BLK; r++)
      for (int k = 0; k < N; k++)
        rows[r][k*PB +: PB] = (r == 0) ? 8'd10 : (r < 3) ? 8'd13 : PB'(20 + r + k);
    run_block(2, -1, 0, -1, -1);
    chk("m2_count", cap_n, 7);
    chk("m2_row0", cap[0], all_0c);
    chk("m2_row1", cap[1], all_0d);

    // Mode 0 with 3 stall cycles mid-block
    for (int r = 0; r < BLK; r++)
      for (int k = 0; k < N; k++) rows[r][k*PB +: PB] = PB'(k * 3 + r * 5);
    run_block(0, 3, 3, -1, -1);
    chk("bp_count", cap_n, 8);
    chk("bp_row3", cap[3], rows[3][(N-1)*PB-1:0]);
    chk("bp_row7", cap[7], rows[7][(N-1)*PB-1:0]);

    // start while busy (would switch to mode 3) must be ignored
    for (int r = 0; r < BLK; r++)
      for (int k = 0; k < N; k++) rows[r][k*PB +: PB] = PB'(k);
    run_block(1, -1, 0, 4, -1);
    chk("ign_count", cap_n, 8);
    chk("ign_row5", cap[5], 56'h07060504030201);

    // Reset mid-block, then a clean block
    run_block(2, -1, 0, -1, 4);
    check_zero("post_reset");
    run_block(1, -1, 0, -1, -1);
    chk("rst_count", cap_n, 8);
    chk("rst_row0", cap[0], 56'h07060504030201);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/halfpel_filter_stream.md
# halfpel_filter_stream

Streaming, parametrised half-pel interpolation filter for the motion-compensation datapath. It accepts one row of `N_PIX` reference pixels per handshake and emits one row of `N_PIX-1` interpolated pixels in one of four modes: full-pel copy, horizontal half, vertical half, or diagonal half. A row register holds the previous row for the vertical and diagonal modes. Rows are framed into blocks of `BLK_ROWS` input rows started by a `start` pulse; the block sits between the reference-row fetch and the prediction buffer.

## Interface
- `PIX_BITS`, 8, bits per pixel
- `N_PIX`, 8, input pixels per row (≥2); output has `N_PIX-1` pixels
- `BLK_ROWS`, 8, input rows per block (≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  block start pulse, sampled only in IDLE
- `mode`  in  2  0 copy, 1 horizontal, 2 vertical, 3 diagonal; sampled with `start`
- `in_valid`  in  1  input row valid
- `in_ready`  out  1  input row accepted when `in_valid & in_ready`
- `in_pix`  in  `N_PIX*PIX_BITS`  pixel k at bits [k*PIX_BITS +: PIX_BITS]
- `out_valid`  out  1  output row valid
- `out_ready`  in  1  output row consumed when `out_valid & out_ready`
- `out_pix`  out  `(N_PIX-1)*PIX_BITS`  same packing as `in_pix`
- `out_last`  out  1  qualifies the final output row of the block
- `busy`  out  1  high from the `start` accept until the block completes
- `blk_done`  out  1  one-cycle pulse on the cycle the last output row is consumed

## Operation
- The FSM has three states: IDLE, PRIME, RUN.
- IDLE: when `start` is high, latch `mode` and clear the row counter. The next state is PRIME for modes 2/3 and RUN for modes 0/1. `start` outside IDLE is ignored.
- PRIME: `in_ready`=1. The accepted row is stored in `prev_row`, no output is produced, and the next state is RUN.
- RUN: `in_ready = !out_valid | out_ready`. Each accepted row produces one output row in the output register, and in modes 2/3 it also replaces `prev_row`.
- With a = current pixel k, b = current pixel k+1, c = `prev_row` pixel k, d = `prev_row` pixel k+1, for k = 0..`N_PIX-2`:
  - mode 0: a
  - mode 1: (a+b+1)>>1, computed at `PIX_BITS+1` bits
  - mode 2: (c+a+1)>>1, computed at `PIX_BITS+1` bits
  - mode 3: (a+b+c+d+2)>>2, computed at `PIX_BITS+2` bits
  - Results never exceed 2^`PIX_BITS`-1, so no saturation is needed.
- The row counter counts accepted input rows, including the priming row.
- The output produced from input row `BLK_ROWS` carries `out_last`=1.
- Output rows per block: `BLK_ROWS` in modes 0/1, `BLK_ROWS-1` in modes 2/3.
- When the `out_last` row is consumed: pulse `blk_done`, drop `busy`, return to IDLE.
- After the last input row is accepted, `in_ready`=0 until IDLE.
- Reset values: `in_ready`, `out_valid`, `out_last`, `busy`, `blk_done` = 0; `out_pix`, `prev_row`, row counter = 0; state = IDLE.
- Reset asserted mid-block discards all state; no partial `blk_done` is produced.

## Timing
- Latency: an input accepted at edge N makes `out_valid`=1 after edge N, with data stable until consumed.
- Throughput is one row per cycle when `out_ready` is held high. Accept and consume in the same cycle is allowed.
- Backpressure: while `out_valid & !out_ready`, `in_ready`=0, and `out_pix`/`out_last` hold.
- `busy` rises the cycle after the `start` accept. The earliest new `start` accept is the cycle after `blk_done`.
- `in_ready` is registered or derived only from state, `out_valid` and `out_ready`. There is no combinational path from `in_valid`.

## Test plan
- Mode 1, `N_PIX`=8, row 0,1,...,7, `out_ready`=1:
  - output 1,2,3,4,5,6,7 (rounded up).
  - `out_valid` one cycle after accept.
  - 8 rows out, `out_last` on the 8th, `blk_done` on the same edge as that consume.
- Mode 3 with all pixels 255 for every row: every output is 255 (no overflow). Only 7 output rows per block, and no output for the priming row.
- Mode 2:
  - prime row all 10, next row all 13 → output all 12.
  - following row all 13 → output all 13 (`prev_row` updated).
- Backpressure in mode 0:
  - `out_ready` low for 3 cycles mid-block → `in_ready`=0, `out_pix` held.
  - block completes with no row lost or duplicated.
- `start` pulsed while `busy` → ignored and mode unchanged.
- `rst_n` pulsed low mid-block → all outputs 0 and state IDLE; the next block runs correctly from `start`.
